seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter CLK_HZ, default 10_000_000, clock frequency.
REQ-003 SHALL have parameter SCAN_HZ, default 1000, per-digit slot rate; DIV = CLK_HZ/SCAN_HZ; a multiple of 16, >= 16, else elaboration error.
REQ-004 SHALL have parameter GUARD, default 1, anti-ghosting blank cycles at slot start (0..DIV/16).
REQ-005 SHALL have parameter BLINK_FRAMES, default 250, frames per blink half-period (>= 1).
REQ-006 SHALL have parameter ACTIVE_LOW, default 1: an, seg and dp_out drive 0 when lit.
REQ-007 SHALL have port clock, input, 1, single clock for all state.
REQ-008 SHALL have port reset, input, 1; synchronous, active-high.
REQ-009 SHALL have port content, input, 4*N_DIGITS, hex nibble per digit; digit i = bits [4i+3:4i].
REQ-010 SHALL have port dp, input, N_DIGITS, decimal point per digit.
REQ-011 SHALL have port en, input, N_DIGITS, digit enable; 0 blanks digit and dp.
REQ-012 SHALL have port blink, input, N_DIGITS, per-digit blink request.
REQ-013 SHALL have port bright, input, 4, global brightness 0 (off) .. 15 (full).
REQ-014 SHALL have port an, output, N_DIGITS, one-hot digit anode select (polarity per ACTIVE_LOW).
REQ-015 SHALL have port seg, output, 7, segments {g,f,e,d,c,b,a}; bit 0 = a.
REQ-016 SHALL have port dp_out, output, 1, decimal-point segment.
REQ-017 SHALL have port frame_start, output, 1, one-cycle pulse when digit 0's slot begins.

Function
REQ-018 SHALL run prescaler cnt 0..DIV-1, wrapping to 0; slot tick when cnt == DIV-1.
REQ-019 SHALL advance select on each tick; select N_DIGITS-1 wraps to 0.
REQ-020 SHALL snapshot content, dp, en, blink on the tick where select wraps to 0; whole frame uses snapshot (tear-free); mid-frame input changes take effect the next frame.
REQ-021 SHALL pulse frame_start in the same cycle the snapshot is loaded.
REQ-022 SHALL keep frame counter 0..BLINK_FRAMES-1, incremented per frame; on wrap, toggle blink_phase.
REQ-023 SHALL light digit in current slot only when: snap_en[select], and not (snap_blink[select] and blink_phase == 1), and cnt >= GUARD, and (bright == 15 or cnt < bright*(DIV/16)).
REQ-024 SHALL treat bright == 0 as all digits dark; bright == 15 as lit for every cnt >= GUARD.
REQ-025 SHALL decode nibble as hex 0-F with standard glyphs (b, d lower case).
REQ-026 SHALL, when digit dark, drive all an, seg and dp_out inactive.
REQ-027 SHALL register an, seg, dp_out: exactly 1 cycle latency from cnt/select state to pins.
REQ-028 SHALL, if bright changes mid-slot, apply the new duty from the next cycle (no snapshot for bright).

Reset
REQ-029 SHALL, on reset, clear cnt, select, frame counter, blink_phase and snapshots to 0.
REQ-030 SHALL, on reset, drive an, seg and dp_out inactive and frame_start 0 in the cycle after reset is sampled.
REQ-031 SHALL start the first frame on the first cycle after reset deasserts, with snapshot loaded at that frame's start tick; digit 0 dark until first snapshot.
REQ-032 SHALL, on reset asserted mid-frame, abandon the frame and discard the snapshot; no partial-slot output.

Structure
REQ-033 SHALL place segment glyph constants, the polarity helper and DIV/width computation functions in shared package seg_pkg.
REQ-034 SHALL instantiate one sub-module, seg_decode (combinational nibble -> 7-seg, active-high), polarity applied in seg_scan.

Verification
REQ-035 SHALL use params N_DIGITS=4, CLK_HZ=1600, SCAN_HZ=100 (DIV=16), GUARD=1, BLINK_FRAMES=2, ACTIVE_LOW=1.
REQ-036 SHALL test scan order: content=16'h3210, en=4'hF, bright=15 -> an cycles 1110,1101,1011,0111 every 16 cycles; seg = glyphs 0,1,2,3; frame_start every 64 cycles.
REQ-037 SHALL test PWM/guard: bright=4 -> per slot, an active for exactly cnt 1..3 (3 of 16 cycles); bright=0 -> an stays 4'hF.
REQ-038 SHALL test tearing: change content to 16'hFFFF mid-frame -> remaining slots of that frame show old glyphs; F appears from next frame_start.
REQ-039 SHALL test blink: blink=4'b0001 -> digit 0 lit for 2 frames, dark 2 frames, repeating; digits 1-3 unaffected.
REQ-040 SHALL test reset: assert reset at cnt=7, select=2 for 1 cycle -> next cycle an=4'hF, seg=7'h7F, dp_out=1; scan restarts at select=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared glyph table, blink phase type and elaboration helpers for the
// seven-segment scanner.
package seg_pkg;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // HIDE blanks digits that request blinking.
  typedef enum logic {
    PHASE_SHOW = 1'b0,
    PHASE_HIDE = 1'b1
  } blink_phase_t;

  // Prescaler period in clocks per digit slot.
  function automatic int calc_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Slot length must split into 16 equal brightness steps.
  function automatic bit div_ok(input int div);
    return (div >= 16) && ((div % 16) == 0);
  endfunction

  // Register width able to hold 0..n-1 (at least one bit).
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Map an active-high "lit" pattern onto pin levels.
  function automatic logic [15:0] to_pins(input logic [15:0] lit, input bit active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-high seven-segment glyph.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Hex glyph lookup; b and d use the lower-case shapes.
  always_comb begin
    segs = GLYPH_8;
    case (nibble)
      4'h0: segs = GLYPH_0;
      4'h1: segs = GLYPH_1;
      4'h2: segs = GLYPH_2;
      4'h3: segs = GLYPH_3;
      4'h4: segs = GLYPH_4;
      4'h5: segs = GLYPH_5;
      4'h6: segs = GLYPH_6;
      4'h7: segs = GLYPH_7;
      4'h8: segs = GLYPH_8;
      4'h9: segs = GLYPH_9;
      4'hA: segs = GLYPH_A;
      4'hB: segs = GLYPH_B;
      4'hC: segs = GLYPH_C;
      4'hD: segs = GLYPH_D;
      4'hE: segs = GLYPH_E;
      4'hF: segs = GLYPH_F;
      default: segs = GLYPH_8;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner: tear-free per-frame snapshot, guard
// blanking, 16-step PWM brightness, per-digit blink and registered pins.
module seg_scan
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int CLK_HZ       = 10_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int GUARD        = 1,
  parameter int BLINK_FRAMES = 250,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] content,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   en,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic [3:0]            bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic                  frame_start
);

  localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int CW  = width_for(DIV);
  localparam int SW  = width_for(N_DIGITS);
  localparam int FW  = width_for(BLINK_FRAMES);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [SW-1:0] SEL_LAST   = SW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam bit                  POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_DARK  = N_DIGITS'(to_pins(16'h0000, POL_LOW));
  localparam logic [6:0]          SEG_DARK = 7'(to_pins(16'h0000, POL_LOW));
  localparam logic                DP_DARK  = POL_LOW;

  if (!div_ok(DIV)) begin : g_bad_div
    $error("seg_scan: CLK_HZ/SCAN_HZ must be a multiple of 16 and at least 16");
  end
  if (GUARD < 0 || GUARD > DIV / 16) begin : g_bad_guard
    $error("seg_scan: GUARD must lie in 0..DIV/16");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan: BLINK_FRAMES must be at least 1");
  end
  if (N_DIGITS < 2 || N_DIGITS > 16) begin : g_bad_digits
    $error("seg_scan: N_DIGITS must lie in 2..16");
  end

  logic [CW-1:0]         cnt_reg;
  logic [SW-1:0]         sel_reg;
  logic [FW-1:0]         frame_reg;
  blink_phase_t          phase_reg;
  logic [4*N_DIGITS-1:0] snap_content_reg;
  logic [N_DIGITS-1:0]   snap_dp_reg;
  logic [N_DIGITS-1:0]   snap_en_reg;
  logic [N_DIGITS-1:0]   snap_blink_reg;
  logic                  frame_start_reg;
  logic [N_DIGITS-1:0]   an_reg;
  logic [6:0]            seg_reg;
  logic                  dp_out_reg;

  logic                  tick;
  logic                  frame_wrap;
  logic [31:0]           cnt_w;
  logic [31:0]           duty_lim;
  logic                  duty_ok;
  logic                  lit;
  logic [6:0]            glyph;
  logic [N_DIGITS-1:0]   one_hot;
  logic [N_DIGITS-1:0]   an_lit;
  logic [6:0]            seg_lit;
  logic                  dp_lit;
  logic [3:0]            snap_nib [N_DIGITS];

  assign tick       = (cnt_reg == CNT_LAST);
  assign frame_wrap = tick && (sel_reg == SEL_LAST);

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
    assign snap_nib[gi] = snap_content_reg[4*gi +: 4];
  end

  seg_decode u_decode (
    .nibble (snap_nib[sel_reg]),
    .segs   (glyph)
  );

  // Brightness window is the first bright/16 of the slot; bright changes
  // take effect immediately since they are not part of the snapshot.
  assign cnt_w    = 32'(cnt_reg);
  assign duty_lim = 32'(bright) * 32'(DIV / 16);
  assign duty_ok  = (bright == 4'hF) || (cnt_w < duty_lim);
  assign lit      = snap_en_reg[sel_reg]
                 && !(snap_blink_reg[sel_reg] && (phase_reg == PHASE_HIDE))
                 && (cnt_w >= 32'(GUARD))
                 && duty_ok;

  assign one_hot = {{(N_DIGITS-1){1'b0}}, 1'b1} << sel_reg;
  assign an_lit  = lit ? one_hot : '0;
  assign seg_lit = lit ? glyph : 7'h00;
  assign dp_lit  = lit && snap_dp_reg[sel_reg];

  // Prescaler, digit select, blink timing and the frame snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg          <= '0;
      sel_reg          <= '0;
      frame_reg        <= '0;
      phase_reg        <= PHASE_SHOW;
      snap_content_reg <= '0;
      snap_dp_reg      <= '0;
      snap_en_reg      <= '0;
      snap_blink_reg   <= '0;
      frame_start_reg  <= 1'b0;
    end else begin
      frame_start_reg <= frame_wrap;
      if (tick) begin
        cnt_reg <= '0;
        sel_reg <= (sel_reg == SEL_LAST) ? '0 : sel_reg + SW'(1);
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      if (frame_wrap) begin
        snap_content_reg <= content;
        snap_dp_reg      <= dp;
        snap_en_reg      <= en;
        snap_blink_reg   <= blink;
        if (frame_reg == FRAME_LAST) begin
          frame_reg <= '0;
          phase_reg <= (phase_reg == PHASE_SHOW) ? PHASE_HIDE : PHASE_SHOW;
        end else begin
          frame_reg <= frame_reg + FW'(1);
        end
      end
    end
  end

  // Pin registers: one clock behind the scan state, polarity applied here.
  always_ff @(posedge clock) begin
    if (reset) begin
      an_reg     <= AN_DARK;
      seg_reg    <= SEG_DARK;
      dp_out_reg <= DP_DARK;
    end else begin
      an_reg     <= N_DIGITS'(to_pins(16'(an_lit), POL_LOW));
      seg_reg    <= 7'(to_pins(16'(seg_lit), POL_LOW));
      dp_out_reg <= 1'(to_pins(16'(dp_lit), POL_LOW));
    end
  end

  assign an          = an_reg;
  assign seg         = seg_reg;
  assign dp_out      = dp_out_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: N_DIGITS=4, DIV=16, GUARD=1, BLINK_FRAMES=2, active-low.
module tb_seg_scan;

  logic        clock;
  logic        reset;
  logic [15:0] content;
  logic [3:0]  dp;
  logic [3:0]  en;
  logic [3:0]  blink;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out;
  logic        frame_start;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg_scan #(
    .N_DIGITS     (4),
    .CLK_HZ       (1600),
    .SCAN_HZ      (100),
    .GUARD        (1),
    .BLINK_FRAMES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .content     (content),
    .dp          (dp),
    .en          (en),
    .blink       (blink),
    .bright      (bright),
    .an          (an),
    .seg         (seg),
    .dp_out      (dp_out),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state: cycles since reset release, and the frame's latched inputs.
  int          m_t = 0;
  logic [15:0] m_content = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;
  logic [3:0]  m_blink = '0;
  bit          exp_valid = 0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fs;

  // Every cycle: compare pins with the prediction, then predict the next cycle.
  always @(negedge clock) begin : model_cmp
    int         slot;
    int         digit;
    int         frame;
    bit         lit;
    logic [3:0] sel_mask;
    logic [3:0] nib;
    if (exp_valid) begin
      n_vec++;
      if (an !== exp_an || seg !== exp_seg || dp_out !== exp_dp || frame_start !== exp_fs) begin
        n_miss++;
        $display("FAIL cycle_check t=%0d: an=%b seg=%h dp_out=%b frame_start=%b, required an=%b seg=%h dp_out=%b frame_start=%b",
                 m_t, an, seg, dp_out, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
      end
    end
    if (reset) begin
      exp_an    = 4'hF;
      exp_seg   = 7'h7F;
      exp_dp    = 1'b1;
      exp_fs    = 1'b0;
      m_t       = 0;
      m_content = '0;
      m_dp      = '0;
      m_en      = '0;
      m_blink   = '0;
    end else begin
      slot  = m_t % 16;
      digit = (m_t / 16) % 4;
      frame = m_t / 64;
      lit = m_en[digit] && !(m_blink[digit] && ((frame / 2) % 2 == 1))
            && (slot >= 1) && (bright == 4'd15 || slot < int'(bright));
      sel_mask = 4'b0001 << digit;
      nib      = m_content[4*digit +: 4];
      exp_an   = lit ? ~sel_mask : 4'hF;
      exp_seg  = lit ? ~GLYPH[nib] : 7'h7F;
      exp_dp   = !(lit && m_dp[digit]);
      exp_fs   = ((m_t + 1) % 64 == 0);
      if (slot == 15 && digit == 3) begin
        m_content = content;
        m_dp      = dp;
        m_en      = en;
        m_blink   = blink;
      end
      m_t++;
    end
    exp_valid = 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_fs(output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (frame_start !== 1'b1 && cycles < 200);
    if (frame_start !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_frame_start: no pulse after %0d cycles, required one", cycles);
    end
  endtask

  initial begin : stim
    int         cyc;
    logic [6:1] blink_pat;
    blink_pat = 6'b011001;
    reset   = 1'b1;
    content = '0;
    dp      = '0;
    en      = '0;
    blink   = '0;
    bright  = 4'hF;

    // Reset state
    @(negedge clock);
    chk("reset_an", 32'(an), 32'h0000000F);
    chk("reset_seg", 32'(seg), 32'h0000007F);
    chk("reset_dp", 32'(dp_out), 32'h00000001);
    chk("reset_fs", 32'(frame_start), 32'h00000000);
    @(posedge clock); #2;
    reset   = 1'b0;
    content = 16'h3210;
    en      = 4'hF;
    dp      = 4'b0100;

    // Scan order and glyphs
    wait_fs(cyc);
    skip(1);  chk("guard_an", 32'(an), 32'h0000000F);
    skip(1);  chk("scan_d0_an", 32'(an), 32'h0000000E);
              chk("scan_d0_seg", 32'(seg), 32'h00000040);
              chk("scan_d0_dp", 32'(dp_out), 32'h00000001);
    skip(16); chk("scan_d1_an", 32'(an), 32'h0000000D);
              chk("scan_d1_seg", 32'(seg), 32'h00000079);
    skip(16); chk("scan_d2_an", 32'(an), 32'h0000000B);
              chk("scan_d2_seg", 32'(seg), 32'h00000024);
              chk("scan_d2_dp", 32'(dp_out), 32'h00000000);
    skip(16); chk("scan_d3_an", 32'(an), 32'h00000007);
              chk("scan_d3_seg", 32'(seg), 32'h00000030);
    wait_fs(cyc);
    chk("frame_period_tail", 32'(cyc), 32'd14);

    // PWM and guard at bright=4, then dark at bright=0
    @(posedge clock); #2;
    bright = 4'd4;
    wait_fs(cyc);
    skip(1); chk("pwm_cnt0_an", 32'(an), 32'h0000000F);
    skip(1); chk("pwm_cnt1_an", 32'(an), 32'h0000000E);
    skip(2); chk("pwm_cnt3_an", 32'(an), 32'h0000000E);
    skip(1); chk("pwm_cnt4_an", 32'(an), 32'h0000000F);
    @(posedge clock); #2;
    bright = 4'd0;
    wait_fs(cyc);
    skip(2);  chk("bright0_d0_an", 32'(an), 32'h0000000F);
    skip(16); chk("bright0_d1_an", 32'(an), 32'h0000000F);

    // Tear-free: content change mid-frame waits for the next frame
    @(posedge clock); #2;
    bright = 4'hF;
    wait_fs(cyc);
    skip(20);
    @(posedge clock); #2;
    content = 16'hFFFF;
    @(negedge clock);
    skip(13); chk("tear_d2_seg", 32'(seg), 32'h00000024);
              chk("tear_d2_an", 32'(an), 32'h0000000B);
    skip(16); chk("tear_d3_seg", 32'(seg), 32'h00000030);
    wait_fs(cyc);
    skip(2);  chk("tear_new_seg", 32'(seg), 32'h0000000E);
              chk("tear_new_an", 32'(an), 32'h0000000E);

    // Reset pulse while the state is cnt=7, select=2
    @(posedge clock); #2;
    content = 16'h3210;
    @(negedge clock);
    skip(35); chk("pre_reset_an", 32'(an), 32'h0000000B);
    @(posedge clock); #2;
    reset = 1'b1;
    blink = 4'b0001;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_an", 32'(an), 32'h0000000F);
    chk("midreset_seg", 32'(seg), 32'h0000007F);
    chk("midreset_dp", 32'(dp_out), 32'h00000001);
    chk("midreset_fs", 32'(frame_start), 32'h00000000);
    wait_fs(cyc);
    chk("restart_to_frame_start", 32'(cyc), 32'd64);

    // Blink on digit 0: frames 1..6 after reset go lit,dark,dark,lit,lit,dark
    for (int f = 1; f <= 6; f++) begin
      if (f > 1) wait_fs(cyc);
      skip(2);
      chk($sformatf("blink_f%0d_d0_an", f), 32'(an), blink_pat[f] ? 32'h0000000E : 32'h0000000F);
      skip(16);
      chk($sformatf("blink_f%0d_d1_an", f), 32'(an), 32'h0000000D);
    end

    skip(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
